// File: rtl/puls_sync_pkg.sv
// -----------------------------------------------------------------------------
// puls_sync_pkg
//   Shared definitions for the pulse event queue and the pulse handshake
//   synchronizer that it feeds.
//
//   Contents
//     DEF_CNT_W    : default width of the pending-event counter
//     DEF_BUSY_TMO : default number of cycles to wait for ready to drop
//     evt_state_e  : issue FSM states (IDLE, WAIT_LOW, WAIT_HIGH)
//     tmo_width()  : bits needed for a counter that runs 0 .. n-1
// -----------------------------------------------------------------------------
package puls_sync_pkg;

   localparam int DEF_CNT_W    = 4;
   localparam int DEF_BUSY_TMO = 8;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_LOW  = 2'd1,
      ST_WAIT_HIGH = 2'd2
   } evt_state_e;

   // Width of a counter that only ever holds 0 .. n-1. Never narrower than
   // one bit so a degenerate BUSY_TMO of 1 still elaborates.
   function automatic int tmo_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage : puls_sync_pkg

// File: rtl/puls_evt_queue_if.sv
// -----------------------------------------------------------------------------
// puls_evt_queue_if
//   Bundles the event request side, the synchronizer handshake and the status
//   outputs of puls_evt_queue.
//
//   Signals
//     i_evt        : single-cycle event request from the source logic
//     i_sync_ready : ready from the downstream pulse handshake synchronizer
//     i_ovf_clr    : clears the sticky overflow flag
//     o_src_puls   : single-cycle pulse to the synchronizer
//     o_pend_cnt   : events queued but not yet issued
//     o_full       : queue at its maximum count
//     o_ovf        : sticky, an event was dropped
//     o_tmo        : single-cycle, a ready-fall timeout occurred
//
//   Modports
//     master : the side that raises events and watches status
//     slave  : the queue itself
// -----------------------------------------------------------------------------
interface puls_evt_queue_if
   import puls_sync_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
);

   logic             i_evt;
   logic             i_sync_ready;
   logic             i_ovf_clr;
   logic             o_src_puls;
   logic [CNT_W-1:0] o_pend_cnt;
   logic             o_full;
   logic             o_ovf;
   logic             o_tmo;

   modport master (
      output i_evt,
      output i_sync_ready,
      output i_ovf_clr,
      input  o_src_puls,
      input  o_pend_cnt,
      input  o_full,
      input  o_ovf,
      input  o_tmo
   );

   modport slave (
      input  i_evt,
      input  i_sync_ready,
      input  i_ovf_clr,
      output o_src_puls,
      output o_pend_cnt,
      output o_full,
      output o_ovf,
      output o_tmo
   );

endinterface : puls_evt_queue_if

// File: rtl/puls_pend_cntr.sv
// -----------------------------------------------------------------------------
// puls_pend_cntr
//   Saturating up/down counter of pending events.
//
//   Ports
//     clk    : clock
//     rst    : asynchronous reset, active-high
//     inc_i  : an event wants to be queued this cycle
//     dec_i  : a stored event is being issued this cycle
//     cnt_o  : current count (registered)
//     full_o : count equals 2^CNT_W-1 (combinational from the register)
//     drop_o : the increment request of this cycle is being discarded
//
//   An increment at full is only accepted when a decrement happens in the
//   same cycle; the count then stays at its maximum. A decrement at zero is
//   ignored so the count can never wrap downwards.
// -----------------------------------------------------------------------------
module puls_pend_cntr #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             full_o,
   output logic             drop_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dec_eff;
   logic             inc_eff;
   logic             full;

   assign full = (cnt_q == CNT_MAX);

   always_comb begin
      cnt_d   = cnt_q;
      dec_eff = dec_i && (cnt_q != '0);
      // A same-cycle decrement frees the slot the new event needs.
      inc_eff = inc_i && (!full || dec_eff);
      drop_o  = inc_i && full && !dec_eff;

      case ({inc_eff, dec_eff})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign full_o = full;

endmodule : puls_pend_cntr

// File: rtl/puls_evt_queue.sv
// -----------------------------------------------------------------------------
// puls_evt_queue
//   Queues single-cycle source events and feeds them one at a time to a pulse
//   handshake synchronizer. Each issue is a one-cycle pulse on o_src_puls,
//   after which the block waits for the synchronizer's ready to fall
//   (WAIT_LOW) and rise again (WAIT_HIGH) before the next issue.
//
//   Ports
//     i_src_clk : the only clock
//     rst       : asynchronous reset, active-high
//     q_if      : puls_evt_queue_if slave (events, handshake, status)
//
//   Behaviour notes
//     - An event arriving on an empty queue while ready is high and the FSM is
//       in IDLE is issued directly without touching the counter.
//     - If ready never falls in WAIT_LOW the FSM gives up after BUSY_TMO
//       cycles, flags o_tmo for one cycle and proceeds to WAIT_HIGH.
//     - WAIT_HIGH has no timeout: a synchronizer that never returns ready
//       stalls the queue, which then fills and raises o_ovf.
//     - o_full is combinational from the count; every other output is a
//       register.
// -----------------------------------------------------------------------------
module puls_evt_queue
   import puls_sync_pkg::*;
#(
   parameter int CNT_W    = DEF_CNT_W,
   parameter int BUSY_TMO = DEF_BUSY_TMO
) (
   input  logic            i_src_clk,
   input  logic            rst,
   puls_evt_queue_if.slave q_if
);

   localparam int               TMO_W    = tmo_width(BUSY_TMO);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);

   evt_state_e       state_q, state_d;
   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             src_puls_q, src_puls_d;
   logic             tmo_q, tmo_d;
   logic             ovf_q, ovf_d;

   logic             issue;
   logic             bypass;
   logic             have_pend;
   logic             cnt_inc;
   logic             cnt_dec;
   logic             cnt_full;
   logic             cnt_drop;
   logic [CNT_W-1:0] pend_cnt;

   assign have_pend = (pend_cnt != '0);

   // Issue FSM and ready-fall timeout.
   always_comb begin
      state_d    = state_q;
      tmo_cnt_d  = tmo_cnt_q;
      src_puls_d = 1'b0;
      tmo_d      = 1'b0;
      issue      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            tmo_cnt_d = '0;
            if ((have_pend || q_if.i_evt) && q_if.i_sync_ready) begin
               issue      = 1'b1;
               src_puls_d = 1'b1;
               state_d    = ST_WAIT_LOW;
            end
         end

         ST_WAIT_LOW: begin
            if (!q_if.i_sync_ready) begin
               state_d   = ST_WAIT_HIGH;
               tmo_cnt_d = '0;
            end else if (tmo_cnt_q == TMO_LAST) begin
               // BUSY_TMO cycles with ready still high: assume the
               // synchronizer missed the fall and move on.
               state_d   = ST_WAIT_HIGH;
               tmo_cnt_d = '0;
               tmo_d     = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end

         ST_WAIT_HIGH: begin
            tmo_cnt_d = '0;
            if (q_if.i_sync_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            tmo_cnt_d = '0;
         end
      endcase
   end

   // An issue takes a stored entry when one exists; otherwise it must be the
   // event of this very cycle, which then never enters the counter.
   assign bypass  = issue && !have_pend;
   assign cnt_dec = issue && have_pend;
   assign cnt_inc = q_if.i_evt && !bypass;

   // A drop in the same cycle as a clear leaves the flag set.
   always_comb begin
      ovf_d = ovf_q;
      if (cnt_drop) begin
         ovf_d = 1'b1;
      end else if (q_if.i_ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge i_src_clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tmo_cnt_q  <= '0;
         src_puls_q <= 1'b0;
         tmo_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmo_cnt_q  <= tmo_cnt_d;
         src_puls_q <= src_puls_d;
         tmo_q      <= tmo_d;
         ovf_q      <= ovf_d;
      end
   end

   puls_pend_cntr #(
      .CNT_W (CNT_W)
   ) u_pend_cntr (
      .clk    (i_src_clk),
      .rst    (rst),
      .inc_i  (cnt_inc),
      .dec_i  (cnt_dec),
      .cnt_o  (pend_cnt),
      .full_o (cnt_full),
      .drop_o (cnt_drop)
   );

   assign q_if.o_src_puls = src_puls_q;
   assign q_if.o_pend_cnt = pend_cnt;
   assign q_if.o_full     = cnt_full;
   assign q_if.o_ovf      = ovf_q;
   assign q_if.o_tmo      = tmo_q;

endmodule : puls_evt_queue

// File: tb/tb_puls_evt_queue.sv
// -----------------------------------------------------------------------------
// tb_puls_evt_queue
//   Directed bench for puls_evt_queue. Inputs change on the falling edge of
//   the source clock; a monitor samples outputs 1 time unit after each rising
//   edge and keeps per-test statistics (pulse count, spacing, peak count,
//   timeout count). A small behavioural toggle synchronizer with a slow
//   destination clock provides ready for the end-to-end test.
// -----------------------------------------------------------------------------
module tb_puls_evt_queue;
   import puls_sync_pkg::*;

   localparam int CW = DEF_CNT_W;

   logic src_clk = 1'b0;
   logic dst_clk = 1'b0;
   logic rst     = 1'b1;

   always #2  src_clk = ~src_clk;
   always #10 dst_clk = ~dst_clk;

   puls_evt_queue_if #(.CNT_W(CW)) q_if ();

   puls_evt_queue #(
      .CNT_W    (CW),
      .BUSY_TMO (DEF_BUSY_TMO)
   ) dut (
      .i_src_clk (src_clk),
      .rst       (rst),
      .q_if      (q_if)
   );

   // ---------------- behavioural toggle synchronizer ----------------
   logic ready_drv = 1'b0;
   logic e2e       = 1'b0;
   logic req_q, ack_s1_q, ack_s2_q;
   logic s1_q, s2_q, s3_q;
   int   dst_cnt = 0;

   always @(posedge src_clk or posedge rst) begin
      if (rst) begin
         req_q    <= 1'b0;
         ack_s1_q <= 1'b0;
         ack_s2_q <= 1'b0;
      end else begin
         if (q_if.o_src_puls) req_q <= ~req_q;
         ack_s1_q <= s2_q;
         ack_s2_q <= ack_s1_q;
      end
   end

   always @(posedge dst_clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= req_q;
         s2_q <= s1_q;
         s3_q <= s2_q;
         if (s2_q != s3_q) dst_cnt <= dst_cnt + 1;
      end
   end

   assign q_if.i_sync_ready = e2e ? (req_q == ack_s2_q) : ready_drv;

   // ---------------- monitor ----------------
   int epoch      = 0;
   int seen_epoch = 0;
   int mcyc       = 0;
   int puls_cnt   = 0;
   int tmo_cnt    = 0;
   int min_gap    = 1000;
   int last_puls  = -1;
   int max_pend   = 0;

   always begin
      @(posedge src_clk);
      #1;
      mcyc = mcyc + 1;
      if (epoch != seen_epoch) begin
         seen_epoch = epoch;
         puls_cnt   = 0;
         tmo_cnt    = 0;
         min_gap    = 1000;
         last_puls  = -1;
         max_pend   = 0;
      end
      if (q_if.o_src_puls) begin
         puls_cnt = puls_cnt + 1;
         if (last_puls >= 0 && (mcyc - last_puls) < min_gap) min_gap = mcyc - last_puls;
         last_puls = mcyc;
      end
      if (q_if.o_tmo) tmo_cnt = tmo_cnt + 1;
      if (int'(q_if.o_pend_cnt) > max_pend) max_pend = int'(q_if.o_pend_cnt);
   end

   // ---------------- checking ----------------
   int tests_run = 0;
   int fails     = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      tests_run++;
      if (obs != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         $display("[TB] pass %s = %0d", tag, obs);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge src_clk);
   endtask

   task automatic fire(input int n);
      q_if.i_evt = 1'b1;
      step(n);
      q_if.i_evt = 1'b0;
   endtask

   task automatic new_epoch();
      epoch++;
      step(1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(1);
   endtask

   task automatic wait_puls(input int target, input int budget);
      int i;
      i = 0;
      while (puls_cnt < target && i < budget) begin
         step(1);
         i++;
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int base;
      int i;
      q_if.i_evt     = 1'b0;
      q_if.i_ovf_clr = 1'b0;
      rst            = 1'b1;
      step(3);
      rst = 1'b0;
      step(1);

      // Reset state
      chk("rst_puls", int'(q_if.o_src_puls), 0);
      chk("rst_pend", int'(q_if.o_pend_cnt), 0);
      chk("rst_full", int'(q_if.o_full), 0);
      chk("rst_ovf",  int'(q_if.o_ovf), 0);
      chk("rst_tmo",  int'(q_if.o_tmo), 0);

      // Single event on empty queue: pulse next cycle, counter bypassed,
      // timeout 8 cycles after the pulse since ready never falls.
      ready_drv = 1'b1;
      new_epoch();
      step(5);
      q_if.i_evt = 1'b1;
      step(1);
      q_if.i_evt = 1'b0;
      chk("single_puls_n1", int'(q_if.o_src_puls), 1);
      chk("single_pend_n1", int'(q_if.o_pend_cnt), 0);
      step(1);
      chk("single_puls_n2", int'(q_if.o_src_puls), 0);
      step(6);
      chk("single_tmo_n8", int'(q_if.o_tmo), 0);
      step(1);
      chk("single_tmo_n9", int'(q_if.o_tmo), 1);
      step(1);
      chk("single_tmo_n10", int'(q_if.o_tmo), 0);
      step(5);
      chk("single_pend_peak", max_pend, 0);
      chk("single_puls_total", puls_cnt, 1);

      // Burst of 5 with ready held high
      new_epoch();
      fire(5);
      wait_puls(5, 300);
      step(15);
      chk("burst_puls", puls_cnt, 5);
      chk("burst_peak", max_pend, 4);
      chk("burst_gap_ge3", int'(min_gap >= 3), 1);
      chk("burst_pend_end", int'(q_if.o_pend_cnt), 0);
      chk("burst_tmo", tmo_cnt, 5);

      // Timeout: 2 events, ready constantly high
      new_epoch();
      fire(2);
      wait_puls(2, 100);
      step(15);
      chk("tmo_count", tmo_cnt, 2);
      chk("tmo_puls", puls_cnt, 2);
      chk("tmo_gap", min_gap, 10);

      // Overflow: ready low, 17 events
      ready_drv = 1'b0;
      new_epoch();
      q_if.i_evt = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         step(1);
         if (k == 15) begin
            chk("ovf_pend_15", int'(q_if.o_pend_cnt), 15);
            chk("ovf_full_15", int'(q_if.o_full), 1);
            chk("ovf_flag_15", int'(q_if.o_ovf), 0);
         end
         if (k == 16) begin
            chk("ovf_pend_16", int'(q_if.o_pend_cnt), 15);
            chk("ovf_flag_16", int'(q_if.o_ovf), 1);
         end
      end
      q_if.i_evt = 1'b0;
      chk("ovf_pend_17", int'(q_if.o_pend_cnt), 15);
      q_if.i_ovf_clr = 1'b1;
      step(1);
      q_if.i_ovf_clr = 1'b0;
      chk("ovf_clr", int'(q_if.o_ovf), 0);
      // Drop and clear together: set wins
      q_if.i_evt     = 1'b1;
      q_if.i_ovf_clr = 1'b1;
      step(1);
      q_if.i_evt     = 1'b0;
      q_if.i_ovf_clr = 1'b0;
      chk("ovf_set_wins", int'(q_if.o_ovf), 1);
      chk("ovf_set_pend", int'(q_if.o_pend_cnt), 15);
      q_if.i_ovf_clr = 1'b1;
      step(1);
      q_if.i_ovf_clr = 1'b0;
      chk("ovf_clr2", int'(q_if.o_ovf), 0);
      new_epoch();
      ready_drv = 1'b1;
      wait_puls(15, 400);
      step(15);
      chk("ovf_drain_puls", puls_cnt, 15);
      chk("ovf_drain_pend", int'(q_if.o_pend_cnt), 0);
      chk("ovf_drain_full", int'(q_if.o_full), 0);
      chk("ovf_drain_gap_ge3", int'(min_gap >= 3), 1);

      // Full with same-cycle decrement: event accepted, count stays 15
      ready_drv = 1'b0;
      fire(15);
      chk("fulldec_pre_pend", int'(q_if.o_pend_cnt), 15);
      new_epoch();
      ready_drv  = 1'b1;
      q_if.i_evt = 1'b1;
      step(1);
      q_if.i_evt = 1'b0;
      chk("fulldec_puls", int'(q_if.o_src_puls), 1);
      chk("fulldec_pend", int'(q_if.o_pend_cnt), 15);
      chk("fulldec_ovf", int'(q_if.o_ovf), 0);
      chk("fulldec_full", int'(q_if.o_full), 1);
      wait_puls(16, 400);
      step(15);
      chk("fulldec_drain_puls", puls_cnt, 16);
      chk("fulldec_drain_pend", int'(q_if.o_pend_cnt), 0);

      // Reset mid-burst
      ready_drv = 1'b0;
      fire(6);
      chk("rstmid_pre_pend", int'(q_if.o_pend_cnt), 6);
      new_epoch();
      ready_drv = 1'b1;
      rst       = 1'b1;
      step(1);
      chk("rstmid_pend", int'(q_if.o_pend_cnt), 0);
      chk("rstmid_puls", int'(q_if.o_src_puls), 0);
      step(1);
      rst = 1'b0;
      step(20);
      chk("rstmid_no_puls", puls_cnt, 0);
      chk("rstmid_pend_after", int'(q_if.o_pend_cnt), 0);
      fire(1);
      step(3);
      chk("rstmid_next_puls", puls_cnt, 1);
      step(15);

      // End-to-end through the behavioural synchronizer
      e2e = 1'b1;
      do_reset();
      step(10);
      base = dst_cnt;
      new_epoch();
      fire(10);
      i = 0;
      while ((dst_cnt - base) < 10 && i < 3000) begin
         step(1);
         i++;
      end
      step(40);
      chk("e2e_dst_puls", dst_cnt - base, 10);
      chk("e2e_src_puls", puls_cnt, 10);
      chk("e2e_ovf", int'(q_if.o_ovf), 0);
      chk("e2e_pend", int'(q_if.o_pend_cnt), 0);
      chk("e2e_tmo", tmo_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule : tb_puls_evt_queue
